// File: rtl/ysyx_25040111_sbd_pkg.sv
// Shared constants and types for the issue-stage register scoreboard.
//   SBD_NREG   : default number of tracked GPRs (RV32E)
//   SBD_CNT_W  : default per-register pending-write counter width
//   SBD_ADDR_W : register address width
// Optional feature macro used by the top level: YSYX_25040111_SBD_CSR_EN.
package ysyx_25040111_sbd_pkg;

    localparam int unsigned SBD_NREG   = 16;
    localparam int unsigned SBD_CNT_W  = 2;
    localparam int unsigned SBD_ADDR_W = 4;

    typedef logic [SBD_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/ysyx_25040111_sbd_if.sv
// Issue/retire bundle between IDU, scoreboard, EXU and the write-back arbiter.
//   slave  : scoreboard view (decoded-instruction and retire inputs, handshake outputs)
//   master : environment view (IDU/EXU/arbiter side)
interface ysyx_25040111_sbd_if;
    import ysyx_25040111_sbd_pkg::*;

    logic      in_valid;
    logic      in_ready;
    reg_addr_t rs1_addr;
    reg_addr_t rs2_addr;
    logic      rs1_en;
    logic      rs2_en;
    reg_addr_t rd_addr;
    logic      rd_en;
    logic      csr_rd_en;
    logic      csr_wr_en;
    logic      out_valid;
    logic      out_ready;
    logic      wb_valid;
    reg_addr_t wb_addr;
    logic      csr_wb_valid;
    logic      busy;
    logic      err;

    modport slave (
        input  in_valid, rs1_addr, rs2_addr, rs1_en, rs2_en, rd_addr, rd_en,
               csr_rd_en, csr_wr_en, out_ready, wb_valid, wb_addr, csr_wb_valid,
        output in_ready, out_valid, busy, err
    );

    modport master (
        output in_valid, rs1_addr, rs2_addr, rs1_en, rs2_en, rd_addr, rd_en,
               csr_rd_en, csr_wr_en, out_ready, wb_valid, wb_addr, csr_wb_valid,
        input  in_ready, out_valid, busy, err
    );

endinterface

// File: rtl/ysyx_25040111_sbd_cnt.sv
// Saturating pending-write counter for one register.
//   clock, reset : clock and synchronous active-high reset
//   inc          : a writer to this register issues
//   dec          : a write to this register commits
//   zero, full   : counter state flags
//   underflow    : a commit arrived with nothing pending (and no same-cycle issue)
module ysyx_25040111_sbd_cnt #(
    parameter int unsigned CNT_W = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic full,
    output logic underflow
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign zero      = (cnt_q == '0);
    assign full      = (cnt_q == '1);
    assign underflow = dec & ~inc & zero;

    always_comb begin
        cnt_d = cnt_q;
        // Simultaneous issue and commit cancel out.
        if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && !zero) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ysyx_25040111_sbd.sv
// Issue-stage register scoreboard. Holds back the IDU->EXU handshake while a
// source operand (or, optionally, the CSR file) has an uncommitted writer.
//   clock, reset : clock and synchronous active-high reset
//   sbd          : issue/retire bundle (slave modport)
// Macro YSYX_25040111_SBD_CSR_EN adds the CSR-pending flag and its hazard and
// error checks; without it the CSR inputs are ignored.
module ysyx_25040111_sbd
    import ysyx_25040111_sbd_pkg::*;
#(
    parameter int unsigned NREG  = SBD_NREG,
    parameter int unsigned CNT_W = SBD_CNT_W
) (
    input logic                  clock,
    input logic                  reset,
    ysyx_25040111_sbd_if.slave   sbd
);

    localparam int unsigned NADDR = 2 ** SBD_ADDR_W;

    // Flags are sized to the full address space so any address indexes safely;
    // x0 and addresses beyond NREG read as idle and never saturate.
    logic [NADDR-1:0] cnt_zero;
    logic [NADDR-1:0] cnt_full;
    logic [NADDR-1:0] cnt_uflow;

    logic hazard;
    logic csr_hazard;
    logic csr_uflow;
    logic issue;
    logic err_q, err_d;

    assign issue = sbd.out_valid & sbd.out_ready;

    for (genvar r = 0; r < NADDR; r++) begin : g_reg
        if (r == 0 || r >= NREG) begin : g_untracked
            assign cnt_zero[r]  = 1'b1;
            assign cnt_full[r]  = 1'b0;
            assign cnt_uflow[r] = 1'b0;
        end else begin : g_tracked
            logic inc, dec;
            assign inc = issue & sbd.rd_en & (sbd.rd_addr == SBD_ADDR_W'(r));
            assign dec = sbd.wb_valid & (sbd.wb_addr == SBD_ADDR_W'(r));

            ysyx_25040111_sbd_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clock     (clock),
                .reset     (reset),
                .inc       (inc),
                .dec       (dec),
                .zero      (cnt_zero[r]),
                .full      (cnt_full[r]),
                .underflow (cnt_uflow[r])
            );
        end
    end

`ifdef YSYX_25040111_SBD_CSR_EN
    logic csr_pend_q, csr_pend_d;

    assign csr_hazard = csr_pend_q & (sbd.csr_rd_en | sbd.csr_wr_en);
    assign csr_uflow  = sbd.csr_wb_valid & ~csr_pend_q;

    always_comb begin
        csr_pend_d = csr_pend_q;
        // A new writer wins over a same-cycle commit of the previous one.
        if (issue && sbd.csr_wr_en) begin
            csr_pend_d = 1'b1;
        end else if (sbd.csr_wb_valid) begin
            csr_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            csr_pend_q <= 1'b0;
        end else begin
            csr_pend_q <= csr_pend_d;
        end
    end
`else
    logic unused_csr;
    assign unused_csr = ^{sbd.csr_rd_en, sbd.csr_wr_en, sbd.csr_wb_valid};
    assign csr_hazard = 1'b0;
    assign csr_uflow  = 1'b0;
`endif

    assign hazard = (sbd.rs1_en & ~cnt_zero[sbd.rs1_addr])
                  | (sbd.rs2_en & ~cnt_zero[sbd.rs2_addr])
                  | (sbd.rd_en  &  cnt_full[sbd.rd_addr])
                  | csr_hazard;

    assign sbd.out_valid = sbd.in_valid & ~hazard;
    assign sbd.in_ready  = sbd.out_ready & ~hazard;
    assign sbd.busy      = ~&cnt_zero;
    assign sbd.err       = err_q;

    assign err_d = err_q | (|cnt_uflow) | csr_uflow;

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_sbd.sv
// Directed self-checking bench for the register scoreboard. Inputs change on
// the falling edge; combinational outputs are sampled 1 ns later.
module tb_ysyx_25040111_sbd;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;

    ysyx_25040111_sbd_if sbd ();

    ysyx_25040111_sbd u_dut (
        .clock (clock),
        .reset (reset),
        .sbd   (sbd)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b, want %b", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        sbd.in_valid     = 1'b0;
        sbd.rs1_addr     = '0;
        sbd.rs2_addr     = '0;
        sbd.rs1_en       = 1'b0;
        sbd.rs2_en       = 1'b0;
        sbd.rd_addr      = '0;
        sbd.rd_en        = 1'b0;
        sbd.csr_rd_en    = 1'b0;
        sbd.csr_wr_en    = 1'b0;
        sbd.out_ready    = 1'b1;
        sbd.wb_valid     = 1'b0;
        sbd.wb_addr      = '0;
        sbd.csr_wb_valid = 1'b0;
    endtask

    // Advance one clock: let the rising edge happen, come back to the falling
    // edge, drop all inputs to idle.
    task automatic step();
        @(negedge clock);
        clear_inputs();
        #1;
    endtask

    task automatic drive_wr(input logic [3:0] rd);
        sbd.in_valid = 1'b1;
        sbd.rd_en    = 1'b1;
        sbd.rd_addr  = rd;
        #1;
    endtask

    task automatic drive_rd1(input logic [3:0] rs);
        sbd.in_valid = 1'b1;
        sbd.rs1_en   = 1'b1;
        sbd.rs1_addr = rs;
        #1;
    endtask

    task automatic drive_wb(input logic [3:0] a);
        sbd.wb_valid = 1'b1;
        sbd.wb_addr  = a;
        #1;
    endtask

    initial begin
        clear_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;

        // Reset state and plain pass-through.
        check("rst_busy", sbd.busy, 1'b0);
        check("rst_err", sbd.err, 1'b0);
        sbd.in_valid = 1'b1;
        #1;
        check("rst_passthru_valid", sbd.out_valid, 1'b1);
        check("rst_passthru_ready", sbd.in_ready, 1'b1);
        step();

        // Independent stream: write x5, then read x6 back to back.
        drive_wr(4'd5);
        check("indep_wr_valid", sbd.out_valid, 1'b1);
        step();
        drive_rd1(4'd6);
        check("indep_rd_valid", sbd.out_valid, 1'b1);
        check("indep_rd_ready", sbd.in_ready, 1'b1);
        check("indep_busy", sbd.busy, 1'b1);
        step();

        // RAW: reader of x5 stalls; commit in the same cycle gives no bypass.
        drive_rd1(4'd5);
        check("raw_stall_valid", sbd.out_valid, 1'b0);
        check("raw_stall_ready", sbd.in_ready, 1'b0);
        drive_wb(4'd5);
        check("raw_no_bypass", sbd.out_valid, 1'b0);
        step();
        drive_rd1(4'd5);
        check("raw_release", sbd.out_valid, 1'b1);
        check("raw_busy_clear", sbd.busy, 1'b0);
        step();

        // EXU not ready: valid still forwarded, nothing issues or counts.
        drive_wr(4'd5);
        sbd.out_ready = 1'b0;
        #1;
        check("nordy_valid", sbd.out_valid, 1'b1);
        check("nordy_ready", sbd.in_ready, 1'b0);
        step();
        check("nordy_no_count", sbd.busy, 1'b0);

        // Saturation on x7: three writers, the fourth stalls.
        for (int i = 0; i < 3; i++) begin
            drive_wr(4'd7);
            check("sat_fill", sbd.out_valid, 1'b1);
            step();
        end
        drive_wr(4'd7);
        check("sat_stall", sbd.out_valid, 1'b0);
        drive_wb(4'd7);
        check("sat_stall_wb", sbd.out_valid, 1'b0);
        step();
        drive_wr(4'd7);
        check("sat_release", sbd.out_valid, 1'b1);
        step();
        drive_wr(4'd7);
        check("sat_full_again", sbd.out_valid, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            drive_wb(4'd7);
            step();
        end
        check("sat_drained", sbd.busy, 1'b0);
        check("sat_no_err", sbd.err, 1'b0);

        // Simultaneous issue and commit on x3 leaves the count at 1.
        drive_wr(4'd3);
        step();
        drive_wr(4'd3);
        drive_wb(4'd3);
        check("sim_issue", sbd.out_valid, 1'b1);
        step();
        sbd.in_valid = 1'b1;
        sbd.rs2_en   = 1'b1;
        sbd.rs2_addr = 4'd3;
        #1;
        check("sim_still_pending", sbd.out_valid, 1'b0);
        step();
        drive_wb(4'd3);
        step();
        check("sim_drained", sbd.busy, 1'b0);

        // x0 is never tracked; a commit to x0 is not an error.
        drive_wr(4'd0);
        step();
        check("x0_no_busy", sbd.busy, 1'b0);
        drive_wb(4'd0);
        step();
        check("x0_wb_no_err", sbd.err, 1'b0);

`ifdef YSYX_25040111_SBD_CSR_EN
        sbd.in_valid  = 1'b1;
        sbd.csr_wr_en = 1'b1;
        #1;
        check("csr_wr_issue", sbd.out_valid, 1'b1);
        step();
        sbd.in_valid  = 1'b1;
        sbd.csr_rd_en = 1'b1;
        #1;
        check("csr_rd_stall", sbd.out_valid, 1'b0);
        sbd.csr_wb_valid = 1'b1;
        #1;
        check("csr_no_bypass", sbd.out_valid, 1'b0);
        step();
        sbd.in_valid  = 1'b1;
        sbd.csr_rd_en = 1'b1;
        #1;
        check("csr_release", sbd.out_valid, 1'b1);
        step();
        check("csr_no_err", sbd.err, 1'b0);
        sbd.csr_wb_valid = 1'b1;
        step();
        check("csr_stray_err", sbd.err, 1'b1);
`else
        sbd.in_valid  = 1'b1;
        sbd.csr_wr_en = 1'b1;
        #1;
        check("csr_wr_issue", sbd.out_valid, 1'b1);
        step();
        sbd.in_valid  = 1'b1;
        sbd.csr_rd_en = 1'b1;
        #1;
        check("csr_ignored", sbd.out_valid, 1'b1);
        step();
        sbd.csr_wb_valid = 1'b1;
        step();
        check("csr_wb_ignored", sbd.err, 1'b0);
`endif

        // Stray GPR commit to an idle register sets the sticky error.
        drive_wb(4'd9);
        step();
        check("uflow_err", sbd.err, 1'b1);
        step();
        check("uflow_sticky", sbd.err, 1'b1);

        // Reset mid-flight clears counters and error.
        drive_wr(4'd4);
        step();
        drive_wr(4'd4);
        step();
        drive_rd1(4'd4);
        check("mid_stall", sbd.out_valid, 1'b0);
        check("mid_busy", sbd.busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("post_rst_busy", sbd.busy, 1'b0);
        check("post_rst_err", sbd.err, 1'b0);
        drive_rd1(4'd4);
        check("post_rst_issue", sbd.out_valid, 1'b1);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
